// File: rtl/system_key_pio_in.sv
// Avalon-MM input PIO: two-flop sync, per-bit debounce, sticky edge capture, masked level irq.
// Latency: stable follows in_port DEBOUNCE_CYCLES+1 edges after first sampling; reads are combinational.
// Backpressure: none, zero wait states on both reads and writes.
module system_key_pio_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CAPTURE_EDGE    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] clr_bits;
    logic             wr_en;
    logic [31:0]      rdata;
    logic             unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    // A mismatch must persist for DEBOUNCE_CYCLES consecutive edges; any match restarts the count.
    always_comb begin
        stable_d = stable_q;
        upd      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    upd[i]      = 1'b1;
                    stable_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Set is OR-ed in after the clear so a coinciding capture survives a W1C write.
    always_comb begin
        case (CAPTURE_EDGE)
            0:       set_bits = upd & ~stable_d;
            1:       set_bits = upd & stable_d;
            default: set_bits = upd;
        endcase
        clr_bits  = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        edgecap_d = (edgecap_q & ~clr_bits) | set_bits;
        irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync_q    <= '0;
            stable_q  <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= in_port;
            sync_q    <= sync1_q;
            stable_q  <= stable_d;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (address)
            2'd0:    rdata[WIDTH-1:0] = stable_q;
            2'd1:    rdata[WIDTH-1:0] = sync_q;
            2'd2:    rdata[WIDTH-1:0] = irqmask_q;
            default: rdata[WIDTH-1:0] = edgecap_q;
        endcase
    end

    assign readdata = rdata;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_system_key_pio_in.sv
// Three instances (falling / rising / any capture) share stimulus; a window-based model predicts reads.
module tb_system_key_pio_in;

    localparam int W  = 4;
    localparam int D  = 8;
    localparam int NI = 3;

    logic                    clk        = 1'b0;
    logic                    reset_n    = 1'b0;
    logic [1:0]              address    = 2'd0;
    logic                    chipselect = 1'b0;
    logic                    write_n    = 1'b1;
    logic [31:0]             writedata  = 32'd0;
    logic [W-1:0]            in_port    = '0;
    logic [NI-1:0][31:0]     rd_w;
    logic [NI-1:0]           irq_w;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        system_key_pio_in #(
            .WIDTH          (W),
            .DEBOUNCE_CYCLES(D),
            .CAPTURE_EDGE   (g)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .address   (address),
            .chipselect(chipselect),
            .write_n   (write_n),
            .writedata (writedata),
            .in_port   (in_port),
            .readdata  (rd_w[g]),
            .irq       (irq_w[g])
        );
    end

    always #5 clk = ~clk;

    // Reference model: a bit is accepted once its last D synchronized samples all disagree with stable.
    logic [W-1:0] m_s1, m_s2, m_stable;
    logic [W-1:0] m_win [$];
    logic [W-1:0] m_mask [NI];
    logic [W-1:0] m_cap  [NI];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0;
        m_win = {};
        for (int j = 0; j < D; j++) m_win.push_back('0);
        for (int g = 0; g < NI; g++) begin
            m_mask[g] = '0; m_cap[g] = '0;
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] acc, nxt, set, clr;
        m_win.push_back(m_s2);
        if (m_win.size() > D) void'(m_win.pop_front());
        acc = '1;
        foreach (m_win[j]) acc &= (m_win[j] ^ m_stable);
        nxt = m_stable ^ acc;
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
        for (int g = 0; g < NI; g++) begin
            set = (g == 0) ? (acc & ~nxt) : (g == 1) ? (acc & nxt) : acc;
            m_cap[g] = (m_cap[g] & ~clr) | set;
            if (chipselect && !write_n && address == 2'd2) m_mask[g] = writedata[W-1:0];
        end
        m_stable = nxt;
        m_s2 = m_s1;
        m_s1 = in_port;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_edge();
        end
    end

    function automatic logic [31:0] exp_rd(int g, logic [1:0] a);
        logic [31:0] r = '0;
        case (a)
            2'd0:    r[W-1:0] = m_stable;
            2'd1:    r[W-1:0] = m_s2;
            2'd2:    r[W-1:0] = m_mask[g];
            default: r[W-1:0] = m_cap[g];
        endcase
        return r;
    endfunction

    typedef struct {
        int          inst;
        logic [1:0]  addr;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t sb [$];
    logic chk_vld = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (chk_vld) begin
                while (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (rd_w[e.inst] !== e.rd) begin
                        errors++;
                        $display("FAIL readdata inst%0d addr%0d @%0t: got %h expected %h",
                                 e.inst, e.addr, $time, rd_w[e.inst], e.rd);
                    end
                    checks++;
                    if (irq_w[e.inst] !== e.irq) begin
                        errors++;
                        $display("FAIL irq inst%0d @%0t: got %b expected %b",
                                 e.inst, $time, irq_w[e.inst], e.irq);
                    end
                end
            end
        end
    end

    task automatic bus_idle();
        chipselect = 1'b0; write_n = 1'b1; chk_vld = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            bus_idle();
        end
    endtask

    task automatic set_in(logic [W-1:0] v);
        @(negedge clk);
        bus_idle();
        in_port = v;
    endtask

    task automatic rd(logic [1:0] a);
        exp_t e;
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        for (int g = 0; g < NI; g++) begin
            e.inst = g; e.addr = a; e.rd = exp_rd(g, a);
            e.irq  = |(m_cap[g] & m_mask[g]);
            sb.push_back(e);
        end
        chk_vld = 1'b1;
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d; chk_vld = 1'b0;
    endtask

    initial begin
        int r;
        in_port = '1;
        rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
        @(negedge clk);
        bus_idle();
        reset_n = 1'b1;
        repeat (D + 4) rd(2'd0);
        rd(2'd3);
        wr(2'd3, 32'hF); wr(2'd2, 32'h0);
        rd(2'd3);

        set_in(4'hE);
        repeat (D + 3) rd(2'd0);
        set_in(4'hF); idle(4); set_in(4'hE);
        repeat (D + 3) rd(2'd0);
        rd(2'd3);

        wr(2'd3, 32'hF); wr(2'd2, 32'h2);
        set_in(4'hC);
        repeat (D + 3) rd(2'd3);
        wr(2'd3, 32'h2); rd(2'd3); rd(2'd2);

        wr(2'd2, 32'h0);
        set_in(4'h8);
        repeat (D + 3) rd(2'd3);
        wr(2'd2, 32'h4); rd(2'd3);

        // bit3 acceptance lands on the same edge as the W1C write
        wr(2'd3, 32'hF);
        set_in(4'h0); idle(D); wr(2'd3, 32'h8);
        rd(2'd3); rd(2'd0); rd(2'd1);

        set_in(4'hF);
        repeat (D + 3) rd(2'd3);

        set_in(4'h0); idle(4);
        @(negedge clk); bus_idle(); reset_n = 1'b0;
        in_port = 4'hF;
        rd(2'd0); rd(2'd3);
        @(negedge clk); bus_idle(); reset_n = 1'b1;
        repeat (D + 4) rd(2'd0);

        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0) set_in(W'($urandom));
            else if (r == 1) set_in(in_port ^ W'(1 << $urandom_range(0, W - 1)));
            else if (r == 2) wr(2'($urandom_range(0, 3)), $urandom);
            else if (r == 3) wr(2'd3, 32'($urandom_range(0, 15)));
            else rd(2'($urandom_range(0, 3)));
        end

        idle(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
